// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_pkg;

  // Default operand widths: dividend/quotient and divisor/remainder.
  localparam int NW_DEF = 8;
  localparam int DW_DEF = 7;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that must hold the values 0..nw.
  function automatic int step_cnt_width(input int nw);
    return $clog2(nw + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed by the parent while running.
module div_step #(
  parameter int DW = 7
) (
  input  logic [DW:0]   rem_i,   // partial remainder before this step
  input  logic          bit_i,   // next dividend bit, MSB first
  input  logic [DW-1:0] dvs_i,   // divisor
  output logic [DW:0]   rem_o,   // partial remainder after this step
  output logic          qbit_o   // quotient bit produced by this step
);

  // The shifted value is one bit wider than the partial remainder so the
  // compare against the divisor can never wrap.
  logic [DW+1:0] trial;
  logic [DW+1:0] dvs_ext;

  // Trial subtraction; keep the shifted value when the divisor does not fit.
  always_comb begin
    trial   = {rem_i, bit_i};
    dvs_ext = {2'b00, dvs_i};
    qbit_o  = 1'b0;
    rem_o   = (DW+1)'(trial);
    if (trial >= dvs_ext) begin
      qbit_o = 1'b1;
      rem_o  = (DW+1)'(trial - dvs_ext);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock; optional zero-divisor fast path (DIV_BY_ZERO_EN).
// Latency: NW RUN cycles after the accepting edge, then a one-cycle DONE pulse (NW+2 cycles per division back-to-back).
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped, never queued.
module seq_divider
  import div_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] dividendin,
  input  logic [DW-1:0] divisorin,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          divzero
);

  localparam int CW = step_cnt_width(NW);

  // Reject illegal configurations at elaboration time.
  if (NW < 2 || NW > 32) begin : g_bad_nw
    $error("seq_divider: NW must be within 2..32");
  end
  if (DW < 2 || DW > NW) begin : g_bad_dw
    $error("seq_divider: DW must be within 2..NW");
  end

  state_e        state_q;
  // Working register: dividend bits leave at the MSB while quotient bits
  // enter at the LSB, so after NW steps it holds the full quotient.
  logic [NW-1:0] work_q;
  logic [NW-1:0] work_d;
  logic [DW-1:0] dvs_q;
  logic [DW:0]   rem_q;
  logic [DW:0]   rem_d;
  logic [CW-1:0] cnt_q;
  logic          step_qbit;

  logic          busy_q;
  logic          done_q;
  logic [NW-1:0] quo_q;
  logic [DW-1:0] remo_q;

  div_step #(
    .DW(DW)
  ) u_step (
    .rem_i  (rem_q),
    .bit_i  (work_q[NW-1]),
    .dvs_i  (dvs_q),
    .rem_o  (rem_d),
    .qbit_o (step_qbit)
  );

  assign work_d = {work_q[NW-2:0], step_qbit};

`ifdef DIV_BY_ZERO_EN
  logic dz_q;

  // Control FSM plus datapath; a zero divisor skips straight to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q <= dividendin;
            dvs_q  <= divisorin;
            rem_q  <= '0;
            cnt_q  <= '0;
            if (divisorin == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quo_q   <= '1;
              remo_q  <= dividendin[DW-1:0];
              dz_q    <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(NW - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= work_d;
            remo_q  <= rem_d[DW-1:0];
            dz_q    <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign divzero = dz_q;
`else
  // Control FSM plus datapath; a zero divisor simply runs all NW steps,
  // which naturally yields an all-ones quotient and the low dividend bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q  <= dividendin;
            dvs_q   <= divisorin;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(NW - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= work_d;
            remo_q  <= rem_d[DW-1:0];
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign divzero = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = remo_q;

endmodule
